// File: rtl/int_sched.sv
// int_sched: synchronises, edge-latches, masks and prioritises interrupt lines for the CPU,
// then tracks the calli/reti handshake. Define INT_SCHED_RR_EN for rotating priority.
module int_sched #(
    parameter int N_IRQ       = 8,
    parameter int VEC_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] int_e,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_in,
    input  logic             s_calli,
    input  logic             s_reti,
    output logic [N_IRQ-1:0] int_a,
    output logic [VEC_W-1:0] int_vec,
    output logic             busy,
    output logic [N_IRQ-1:0] pending,
    output logic             spurious
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] int_a_q, int_a_d;
    logic [VEC_W-1:0] int_vec_q, int_vec_d;
    logic             spurious_q, spurious_d;
    logic [N_IRQ-1:0] cand;
    logic [N_IRQ-1:0] clr;
    logic             win_found;
    logic [VEC_W-1:0] win_idx;
`ifdef INT_SCHED_RR_EN
    logic [VEC_W-1:0] ptr_q, ptr_d;
    int               rr_j;
`endif

    // A held level produces a single event: only the 0->1 transition after the synchroniser counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= int_e;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign cand = pending_q & mask_q;

`ifdef INT_SCHED_RR_EN
    // Descending scan so the candidate nearest the pointer is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_j      = 0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            rr_j = (int'(ptr_q) + k) % N_IRQ;
            if (cand[rr_j]) begin
                win_found = 1'b1;
                win_idx   = VEC_W'(rr_j);
            end
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (cand[k]) begin
                win_found = 1'b1;
                win_idx   = VEC_W'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        int_a_d    = int_a_q;
        int_vec_d  = int_vec_q;
        spurious_d = spurious_q;
        clr        = '0;
`ifdef INT_SCHED_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_calli || s_reti) spurious_d = 1'b1;
                if (win_found) begin
                    int_a_d   = N_IRQ'(1) << win_idx;
                    int_vec_d = win_idx;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // The grant is frozen here; only calli moves it on.
                if (s_reti) spurious_d = 1'b1;
                if (s_calli) begin
                    clr     = int_a_q;
                    int_a_d = '0;
                    state_d = SERVICE;
`ifdef INT_SCHED_RR_EN
                    ptr_d   = (int_vec_q == VEC_W'(N_IRQ - 1)) ? '0 : int_vec_q + 1'b1;
`endif
                end
            end
            SERVICE: begin
                if (s_calli) spurious_d = 1'b1;
                if (s_reti) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we ? mask_in : mask_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            mask_q     <= '0;
            int_a_q    <= '0;
            int_vec_q  <= '0;
            spurious_q <= 1'b0;
`ifdef INT_SCHED_RR_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            int_a_q    <= int_a_d;
            int_vec_q  <= int_vec_d;
            spurious_q <= spurious_d;
`ifdef INT_SCHED_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign int_a    = int_a_q;
    assign int_vec  = int_vec_q;
    assign busy     = (state_q == SERVICE);
    assign pending  = pending_q;
    assign spurious = spurious_q;

endmodule

// File: tb/tb_int_sched.sv
// Testbench for int_sched: directed steps followed by random traffic, all checked against
// a behavioural model of the request/grant/service rules.
module tb_int_sched;

    localparam int N    = 8;
    localparam int VW   = 3;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  intE;
    logic          maskWe;
    logic [N-1:0]  maskIn;
    logic          sCalli;
    logic          sReti;
    logic [N-1:0]  intA;
    logic [VW-1:0] intVec;
    logic          busyO;
    logic [N-1:0]  pendingO;
    logic          spuriousO;

    int checks = 0;
    int passed = 0;

    // Behavioural model state: sampled input history, latched requests, grant and service status.
    bit [N-1:0] hist [SYNC+2];
    bit [N-1:0] mPend;
    bit [N-1:0] mMask;
    int         mPresented;
    bit         mInSvc;
    bit         mSpur;
    int         mVec;
    int         mPtr;

    logic [N-1:0] rndE;
    logic         rndWe;
    logic [N-1:0] rndMask;
    logic         rndCalli;
    logic         rndReti;

    always #5 clk = ~clk;

    int_sched #(
        .N_IRQ      (N),
        .VEC_W      (VW),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .int_e   (intE),
        .mask_we (maskWe),
        .mask_in (maskIn),
        .s_calli (sCalli),
        .s_reti  (sReti),
        .int_a   (intA),
        .int_vec (intVec),
        .busy    (busyO),
        .pending (pendingO),
        .spurious(spuriousO)
    );

    task automatic modelReset();
        for (int k = 0; k < SYNC + 2; k++) hist[k] = '0;
        mPend      = '0;
        mMask      = '0;
        mPresented = -1;
        mInSvc     = 1'b0;
        mSpur      = 1'b0;
        mVec       = 0;
        mPtr       = 0;
    endtask

    function automatic int pickWinner(bit [N-1:0] cand);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mPtr + k) % N;
            if (cand[idx]) return idx;
        end
        return -1;
    endfunction

    // A request becomes pending SYNC edges after the edge that first samples it high.
    task automatic modelEdge();
        bit [N-1:0] rising;
        bit [N-1:0] clr;
        bit [N-1:0] cand;
        int         win;
        for (int k = SYNC + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = intE;
        rising  = hist[SYNC] & ~hist[SYNC+1];
        clr     = '0;
        cand    = mPend & mMask;
        if (mPresented >= 0) begin
            if (sReti) mSpur = 1'b1;
            if (sCalli) begin
                clr[mPresented] = 1'b1;
`ifdef INT_SCHED_RR_EN
                mPtr = (mPresented + 1) % N;
`endif
                mPresented = -1;
                mInSvc     = 1'b1;
            end
        end else if (mInSvc) begin
            if (sCalli) mSpur = 1'b1;
            if (sReti) mInSvc = 1'b0;
        end else begin
            if (sCalli || sReti) mSpur = 1'b1;
            win = pickWinner(cand);
            if (win >= 0) begin
                mPresented = win;
                mVec       = win;
            end
        end
        mPend = (mPend & ~clr) | rising;
        if (maskWe) mMask = maskIn;
    endtask

    task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic checkOutput(input string tag);
        logic [N-1:0] expA;
        expA = '0;
        if (mPresented >= 0) expA[mPresented] = 1'b1;
        checkOne({tag, ".int_a"}, 32'(intA), 32'(expA));
        checkOne({tag, ".int_vec"}, 32'(intVec), 32'(mVec));
        checkOne({tag, ".busy"}, 32'(busyO), 32'(mInSvc));
        checkOne({tag, ".pending"}, 32'(pendingO), 32'(mPend));
        checkOne({tag, ".spurious"}, 32'(spuriousO), 32'(mSpur));
    endtask

    task automatic applyStimulus(input logic we, input logic [N-1:0] mi, input logic calli,
                                 input logic reti, input logic [N-1:0] e, input string tag);
        maskWe = we;
        maskIn = mi;
        sCalli = calli;
        sReti  = reti;
        intE   = e;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        reset  = 1'b0;
        intE   = '1;
        maskWe = 1'b0;
        maskIn = '0;
        sCalli = 1'b0;
        sReti  = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset");

        // Release with every line high and the mask closed.
        reset = 1'b1;
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0, 8'hFF, "release");
        checkOne("pendAll", 32'(pendingO), 32'h0000_00FF);
        checkOne("maskedNoGrant", 32'(intA), 32'h0);

        // Single request on line 3.
        reset = 1'b0;
        #1;
        modelReset();
        intE  = '0;
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 8'h08, "single");
        repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, 8'h00, "single");
        checkOne("singlePend", 32'(pendingO), 32'h08);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 8'h00, "singleGrant");
        checkOne("singleIntA", 32'(intA), 32'h08);
        checkOne("singleVec", 32'(intVec), 32'd3);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 8'h00, "singleCall");
        checkOne("callBusy", 32'(busyO), 32'd1);
        checkOne("callPend", 32'(pendingO), 32'h0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 8'h00, "singleRet");
        checkOne("retBusy", 32'(busyO), 32'd0);

        // Priority between lines 2 and 5.
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 8'h24, "prio");
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0, 8'h00, "prio");
        checkOne("prioFirst", 32'(intA), 32'h04);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 8'h00, "prioCall");
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 8'h00, "prioRet");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 8'h00, "prioSecond");
        checkOne("prioSecondA", 32'(intA), 32'h20);
        checkOne("prioSecondVec", 32'(intVec), 32'd5);

        // Grant must hold while a new request arrives and the mask closes.
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 8'h01, "stable");
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0, 8'h00, "stable");
        checkOne("stableIntA", 32'(intA), 32'h20);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 8'h00, "stableCall");
        checkOne("stablePend0", 32'(pendingO), 32'h01);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 8'h00, "stableRet");

        // Return with nothing in service.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 8'h00, "idleReti");
        checkOne("idleRetiSpur", 32'(spuriousO), 32'd1);
        checkOne("idleRetiBusy", 32'(busyO), 32'd0);

        // Enter service, then assert reset between clock edges.
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, "svc");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 8'h00, "svcGrant");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 8'h00, "svcCall");
        checkOne("svcBusy", 32'(busyO), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOne("asyncBusy", 32'(busyO), 32'd0);
        checkOne("asyncSpur", 32'(spuriousO), 32'd0);
        checkOne("asyncIntA", 32'(intA), 32'h0);
        modelReset();
        #1;
        reset = 1'b1;

        // Random traffic.
        rndE = '0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) rndE[b] = ~rndE[b];
            rndWe    = ($urandom_range(0, 15) == 0);
            rndMask  = N'($urandom);
            rndCalli = (mPresented >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
            rndReti  = mInSvc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
            applyStimulus(rndWe, rndMask, rndCalli, rndReti, rndE, "rnd");
        end

`ifdef INT_SCHED_RR_EN
        // Lines 1 and 6 kept requesting: grants alternate.
        reset = 1'b0;
        #1;
        modelReset();
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, "rrMask");
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 8'h42, "rr");
            repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0, 8'h00, "rr");
            checkOne("rrVec", 32'(intVec), (r % 2 == 0) ? 32'd1 : 32'd6);
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 8'h00, "rrCall");
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 8'h00, "rrRet");
        end
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
